// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM states and default width.
package serial_subtractor_4bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// Gate-level full subtractor built from NAND-based xor/and/or primitives.

module xor_gate (
  output logic y,
  input  logic a,
  input  logic b
);
  logic n1, n2, n3;
  // Classic four-NAND exclusive-or.
  always_comb begin
    n1 = ~(a & b);
    n2 = ~(a & n1);
    n3 = ~(b & n1);
    y  = ~(n2 & n3);
  end
endmodule

module and_gate (
  output logic y,
  input  logic a,
  input  logic b
);
  logic n1;
  // NAND followed by a NAND wired as an inverter.
  always_comb begin
    n1 = ~(a & b);
    y  = ~(n1 & n1);
  end
endmodule

module or_gate (
  output logic y,
  input  logic a,
  input  logic b
);
  logic na, nb;
  // De Morgan: NAND of the inverted inputs.
  always_comb begin
    na = ~(a & a);
    nb = ~(b & b);
    y  = ~(na & nb);
  end
endmodule

module full_subtractor (
  output logic d,
  output logic bo,
  input  logic x,
  input  logic y,
  input  logic bi
);
  logic x_xor_y;
  logic x_n;
  logic xy_eq;
  logic gen_b;
  logic prop_b;

  // Inverters for ~x and ~(x^y) feeding the borrow generate/propagate terms.
  always_comb begin
    x_n   = ~x;
    xy_eq = ~x_xor_y;
  end

  xor_gate u_xor_xy  (.y(x_xor_y), .a(x),       .b(y));
  xor_gate u_xor_d   (.y(d),       .a(x_xor_y), .b(bi));
  and_gate u_and_gen (.y(gen_b),   .a(x_n),     .b(y));
  and_gate u_and_prp (.y(prop_b),  .a(xy_eq),   .b(bi));
  or_gate  u_or_bo   (.y(bo),      .a(gen_b),   .b(prop_b));

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle, LSB first.
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fs_d;
  logic               fs_bo;
  logic               last_bit;

  full_subtractor u_fs (
    .d  (fs_d),
    .bo (fs_bo),
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (borrow_q)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath updates; partial result shifts in a private
  // register so diff/bout keep the previous result until the final edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          sh_d     = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = fs_bo;
        sh_d     = {fs_d, sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = {fs_d, sh_q[WIDTH-1:1]};
          bout_d  = fs_bo;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      sh_q     <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed + exhaustive bench for serial_subtractor_4bit with a result scoreboard.
module tb_serial_subtractor_4bit;

  typedef struct {
    logic [3:0] diff;
    logic       bout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic       bin;
  logic [3:0] diff;
  logic       bout, busy, done;

  exp_t       sb[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [3:0] last_diff = '0;

  serial_subtractor_4bit #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y, input logic bi);
    exp_t e;
    int   r;
    r = int'(x) - int'(y) - int'(bi);
    e.diff = 4'(r & 15);
    e.bout = (r < 0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.diff));
        chk("bout", 32'(bout), 32'(e.bout));
        last_diff = e.diff;
      end
    end
  end

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // One full operation with handshake-timing checks; ends at a negedge.
  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic bi, input bit timing);
    logic [3:0] prev;
    prev  = last_diff;
    a     = x; b = y; bin = bi; start = 1'b1;
    sb.push_back(model(x, y, bi));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      a = ~x; b = ~y; bin = ~bi;
      if (timing) begin
        chk("busy_shift", 32'(busy), 32'd1);
        chk("done_shift", 32'(done), 32'd0);
        chk("diff_held", 32'(diff), 32'(prev));
      end
    end
    @(negedge clk);
    if (timing) begin
      chk("busy_end", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);
    end
    @(negedge clk);
    if (timing) chk("done_one_cycle", 32'(done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    run_op(4'd9,  4'd5,  1'b0, 1'b1);
    chk("t1_diff_held", 32'(diff), 32'h4);
    run_op(4'd5,  4'd9,  1'b0, 1'b1);
    chk("t2_diff_held", 32'(diff), 32'hC);
    run_op(4'd0,  4'd0,  1'b1, 1'b1);
    chk("t3_bout_held", 32'(bout), 32'd1);
    run_op(4'd15, 4'd15, 1'b0, 1'b1);
    chk("t4_bout_held", 32'(bout), 32'd0);

    // Start in SHIFT must be ignored.
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    sb.push_back(model(4'd9, 4'd5, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_drain("ign_drain");
    repeat (6) @(negedge clk);
    chk("ign_idle_busy", 32'(busy), 32'd0);
    chk("ign_diff", 32'(diff), 32'h4);

    // Reset in the middle of an operation.
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    last_diff = '0;
    repeat (8) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(done), 32'd0);
    end

    // Back-to-back with start held high: one result every 5 cycles.
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] x, y;
      logic       bi;
      x = 4'($urandom_range(0, 15)); y = 4'($urandom_range(0, 15)); bi = 1'($urandom_range(0, 1));
      a = x; b = y; bin = bi;
      sb.push_back(model(x, y, bi));
      repeat (4) begin
        @(negedge clk);
        chk("b2b_no_done", 32'(done), 32'd0);
      end
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy_end", 32'(busy), 32'd0);
    wait_drain("b2b_drain");

    // Exhaustive sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_op(4'(x), 4'(y), 1'(c), 1'b0);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
